// File: rtl/btb_assoc.sv
// N-way set-associative branch target buffer with registered lookup,
// in-place 2-bit counter training, round-robin replacement and flush.
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   flush               invalidate every entry, reset replacement pointers
//   lookup_valid/pc     fetch-stage lookup request
//   pred_valid/hit/target/taken  prediction, one cycle after the request
//   upd_valid/pc/target/taken    resolved-branch training from execute
module btb_assoc #(
    parameter int NUM_SETS = 8,
    parameter int NUM_WAYS = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        lookup_valid,
    input  logic [31:0] lookup_pc,
    output logic        pred_valid,
    output logic        pred_hit,
    output logic [31:0] pred_target,
    output logic        pred_taken,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic [31:0] upd_target,
    input  logic        upd_taken
);

    localparam int IDX_W = $clog2(NUM_SETS);
    localparam int TAG_W = 30 - IDX_W;
    localparam int WAY_W = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;

    logic             valid_q  [NUM_SETS][NUM_WAYS];
    logic [TAG_W-1:0] tag_q    [NUM_SETS][NUM_WAYS];
    logic [31:0]      target_q [NUM_SETS][NUM_WAYS];
    logic [1:0]       ctr_q    [NUM_SETS][NUM_WAYS];
    logic [WAY_W-1:0] rr_ptr   [NUM_SETS];

    logic [IDX_W-1:0] l_idx;
    logic [TAG_W-1:0] l_tag;
    logic [IDX_W-1:0] u_idx;
    logic [TAG_W-1:0] u_tag;

    assign l_idx = lookup_pc[IDX_W+1:2];
    assign l_tag = lookup_pc[31:IDX_W+2];
    assign u_idx = upd_pc[IDX_W+1:2];
    assign u_tag = upd_pc[31:IDX_W+2];

    // Byte-offset bits never take part in indexing or tagging.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{lookup_pc[1:0], upd_pc[1:0]};

    logic             l_hit;
    logic [WAY_W-1:0] l_way;
    logic             u_hit;
    logic [WAY_W-1:0] u_way;
    logic             u_free;
    logic [WAY_W-1:0] u_free_way;
    logic [WAY_W-1:0] victim;
    logic [1:0]       ctr_cur;
    logic [1:0]       ctr_next;
    logic             do_upd;

    // Ways are scanned high to low so the lowest matching way wins.
    always_comb begin
        l_hit      = 1'b0;
        l_way      = '0;
        u_hit      = 1'b0;
        u_way      = '0;
        u_free     = 1'b0;
        u_free_way = '0;
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (valid_q[l_idx][w] && tag_q[l_idx][w] == l_tag) begin
                l_hit = 1'b1;
                l_way = WAY_W'(w);
            end
            if (valid_q[u_idx][w] && tag_q[u_idx][w] == u_tag) begin
                u_hit = 1'b1;
                u_way = WAY_W'(w);
            end
            if (!valid_q[u_idx][w]) begin
                u_free     = 1'b1;
                u_free_way = WAY_W'(w);
            end
        end
    end

    always_comb begin
        victim = '0;
        if (u_free) begin
            victim = u_free_way;
        end else if (NUM_WAYS > 1) begin
            victim = rr_ptr[u_idx];
        end
    end

    always_comb begin
        ctr_cur  = ctr_q[u_idx][u_way];
        ctr_next = ctr_cur;
        if (upd_taken) begin
            if (ctr_cur != 2'b11) ctr_next = ctr_cur + 2'd1;
        end else begin
            if (ctr_cur != 2'b00) ctr_next = ctr_cur - 2'd1;
        end
    end

    // Flush takes precedence over a same-cycle update.
    assign do_upd = upd_valid && !flush;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int s = 0; s < NUM_SETS; s++) begin
                rr_ptr[s] <= '0;
                for (int w = 0; w < NUM_WAYS; w++) begin
                    valid_q[s][w] <= 1'b0;
                    ctr_q[s][w]   <= 2'b01;
                end
            end
        end else if (flush) begin
            for (int s = 0; s < NUM_SETS; s++) begin
                rr_ptr[s] <= '0;
                for (int w = 0; w < NUM_WAYS; w++) begin
                    valid_q[s][w] <= 1'b0;
                end
            end
        end else if (do_upd) begin
            if (u_hit) begin
                ctr_q[u_idx][u_way] <= ctr_next;
            end else if (upd_taken) begin
                valid_q[u_idx][victim] <= 1'b1;
                ctr_q[u_idx][victim]   <= 2'b10;
                if (!u_free && NUM_WAYS > 1) begin
                    rr_ptr[u_idx] <= rr_ptr[u_idx] + WAY_W'(1);
                end
            end
        end
    end

    // Tag and target payload carries no reset; validity gates its use.
    always_ff @(posedge clk) begin
        if (!reset && do_upd && upd_taken) begin
            if (u_hit) begin
                target_q[u_idx][u_way] <= upd_target;
            end else begin
                tag_q[u_idx][victim]    <= u_tag;
                target_q[u_idx][victim] <= upd_target;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pred_valid  <= 1'b0;
            pred_hit    <= 1'b0;
            pred_target <= '0;
            pred_taken  <= 1'b0;
        end else begin
            pred_valid  <= lookup_valid;
            pred_hit    <= lookup_valid && l_hit;
            pred_target <= (lookup_valid && l_hit) ? target_q[l_idx][l_way] : 32'h0;
            pred_taken  <= lookup_valid && l_hit && ctr_q[l_idx][l_way][1];
        end
    end

endmodule

// File: tb/tb_btb_assoc.sv
// Directed self-checking bench for btb_assoc: default 2-way/8-set
// instance and a 4-way/16-set instance driven by shared stimulus.
module tb_btb_assoc;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic        lookup_valid = 1'b0;
    logic [31:0] lookup_pc = '0;
    logic        upd_valid = 1'b0;
    logic [31:0] upd_pc = '0;
    logic [31:0] upd_target = '0;
    logic        upd_taken = 1'b0;

    logic        a_valid, a_hit, a_taken;
    logic [31:0] a_target;
    logic        b_valid, b_hit, b_taken;
    logic [31:0] b_target;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    btb_assoc dut_a (
        .clk(clk), .reset(reset), .flush(flush),
        .lookup_valid(lookup_valid), .lookup_pc(lookup_pc),
        .pred_valid(a_valid), .pred_hit(a_hit),
        .pred_target(a_target), .pred_taken(a_taken),
        .upd_valid(upd_valid), .upd_pc(upd_pc),
        .upd_target(upd_target), .upd_taken(upd_taken)
    );

    btb_assoc #(.NUM_SETS(16), .NUM_WAYS(4)) dut_b (
        .clk(clk), .reset(reset), .flush(flush),
        .lookup_valid(lookup_valid), .lookup_pc(lookup_pc),
        .pred_valid(b_valid), .pred_hit(b_hit),
        .pred_target(b_target), .pred_taken(b_taken),
        .upd_valid(upd_valid), .upd_pc(upd_pc),
        .upd_target(upd_target), .upd_taken(upd_taken)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", nm, obs, exp);
        end
    endtask

    task automatic pred(input bit sel_b, input string nm, input logic v,
                        input logic h, input logic [31:0] t, input logic k);
        if (sel_b) begin
            chk({nm, ".valid"}, {31'b0, b_valid}, {31'b0, v});
            chk({nm, ".hit"}, {31'b0, b_hit}, {31'b0, h});
            chk({nm, ".target"}, b_target, t);
            chk({nm, ".taken"}, {31'b0, b_taken}, {31'b0, k});
        end else begin
            chk({nm, ".valid"}, {31'b0, a_valid}, {31'b0, v});
            chk({nm, ".hit"}, {31'b0, a_hit}, {31'b0, h});
            chk({nm, ".target"}, a_target, t);
            chk({nm, ".taken"}, {31'b0, a_taken}, {31'b0, k});
        end
    endtask

    task automatic lookup(input logic [31:0] pc);
        lookup_valid = 1'b1;
        lookup_pc = pc;
        cyc();
        lookup_valid = 1'b0;
    endtask

    task automatic update(input logic [31:0] pc, input logic [31:0] tgt, input logic tk);
        upd_valid = 1'b1;
        upd_pc = pc;
        upd_target = tgt;
        upd_taken = tk;
        cyc();
        upd_valid = 1'b0;
    endtask

    task automatic hit_a(input string nm, input logic [31:0] pc,
                         input logic [31:0] t, input logic k);
        lookup(pc);
        pred(1'b0, nm, 1'b1, 1'b1, t, k);
    endtask

    task automatic miss_a(input string nm, input logic [31:0] pc);
        lookup(pc);
        pred(1'b0, nm, 1'b1, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic hit_b(input string nm, input logic [31:0] pc,
                         input logic [31:0] t, input logic k);
        lookup(pc);
        pred(1'b1, nm, 1'b1, 1'b1, t, k);
    endtask

    task automatic miss_b(input string nm, input logic [31:0] pc);
        lookup(pc);
        pred(1'b1, nm, 1'b1, 1'b0, 32'h0, 1'b0);
    endtask

    initial begin
        // ---- default instance: 2 ways, 8 sets ----
        cyc();
        cyc();
        reset = 1'b0;
        pred(1'b0, "a_reset", 1'b0, 1'b0, 32'h0, 1'b0);
        pred(1'b1, "b_reset", 1'b0, 1'b0, 32'h0, 1'b0);
        cyc();
        pred(1'b0, "a_idle", 1'b0, 1'b0, 32'h0, 1'b0);

        miss_a("a_cold", 32'h0000_1000);

        update(32'h0000_1000, 32'h0000_2000, 1'b1);
        hit_a("a_alloc", 32'h0000_1000, 32'h0000_2000, 1'b1);
        update(32'h0000_1000, 32'h0000_9999, 1'b0);
        hit_a("a_nt1", 32'h0000_1000, 32'h0000_2000, 1'b0);
        update(32'h0000_1000, 32'h0000_9999, 1'b0);
        update(32'h0000_1000, 32'h0000_9999, 1'b0);
        hit_a("a_nt3", 32'h0000_1000, 32'h0000_2000, 1'b0);
        // floor held at 00, so one taken step lands on 01
        update(32'h0000_1000, 32'h0000_2000, 1'b1);
        hit_a("a_floor", 32'h0000_1000, 32'h0000_2000, 1'b0);
        update(32'h0000_1000, 32'h0000_2000, 1'b1);
        update(32'h0000_1000, 32'h0000_2000, 1'b1);
        update(32'h0000_1000, 32'h0000_2000, 1'b1);
        update(32'h0000_1000, 32'h0000_2000, 1'b0);
        hit_a("a_ceil", 32'h0000_1000, 32'h0000_2000, 1'b1);

        update(32'h0000_1020, 32'h0000_2020, 1'b1);
        update(32'h0000_1040, 32'h0000_2040, 1'b1);
        miss_a("a_evict0_old", 32'h0000_1000);
        hit_a("a_evict0_w1", 32'h0000_1020, 32'h0000_2020, 1'b1);
        hit_a("a_evict0_new", 32'h0000_1040, 32'h0000_2040, 1'b1);

        update(32'h0000_1060, 32'h0000_2060, 1'b1);
        miss_a("a_evict1_old", 32'h0000_1020);
        hit_a("a_evict1_new", 32'h0000_1060, 32'h0000_2060, 1'b1);
        hit_a("a_evict1_keep", 32'h0000_1040, 32'h0000_2040, 1'b1);

        update(32'h0000_3000, 32'h0000_5000, 1'b0);
        miss_a("a_nt_absent", 32'h0000_3000);
        hit_a("a_nt_keep", 32'h0000_1040, 32'h0000_2040, 1'b1);

        // 0x1000 replaces way 0 (0x1040); pointer moves to 1
        update(32'h0000_1000, 32'h0000_2000, 1'b1);
        lookup_valid = 1'b1;
        lookup_pc = 32'h0000_1000;
        upd_valid = 1'b1;
        upd_pc = 32'h0000_1000;
        upd_target = 32'h0000_4000;
        upd_taken = 1'b1;
        cyc();
        lookup_valid = 1'b0;
        upd_valid = 1'b0;
        pred(1'b0, "a_rbw", 1'b1, 1'b1, 32'h0000_2000, 1'b1);
        hit_a("a_rbw_after", 32'h0000_1000, 32'h0000_4000, 1'b1);

        update(32'h0000_1004, 32'h0000_2004, 1'b1);
        update(32'h0000_1008, 32'h0000_2008, 1'b1);
        flush = 1'b1;
        upd_valid = 1'b1;
        upd_pc = 32'h0000_100C;
        upd_target = 32'h0000_200C;
        upd_taken = 1'b1;
        cyc();
        flush = 1'b0;
        upd_valid = 1'b0;
        miss_a("a_fl_1000", 32'h0000_1000);
        miss_a("a_fl_1060", 32'h0000_1060);
        miss_a("a_fl_1004", 32'h0000_1004);
        miss_a("a_fl_1008", 32'h0000_1008);
        miss_a("a_fl_drop", 32'h0000_100C);
        // flush cleared the set-0 pointer, so the third fill evicts way 0
        update(32'h0000_1020, 32'h0000_3020, 1'b1);
        update(32'h0000_1040, 32'h0000_3040, 1'b1);
        update(32'h0000_1060, 32'h0000_3060, 1'b1);
        miss_a("a_fl_rr_old", 32'h0000_1020);
        hit_a("a_fl_rr_keep", 32'h0000_1040, 32'h0000_3040, 1'b1);

        // ---- reset with a lookup in flight, then 4-way/16-set ----
        lookup_valid = 1'b1;
        lookup_pc = 32'h0000_1040;
        cyc();
        reset = 1'b1;
        cyc();
        lookup_valid = 1'b0;
        reset = 1'b0;
        pred(1'b0, "a_mid_reset", 1'b0, 1'b0, 32'h0, 1'b0);
        pred(1'b1, "b_mid_reset", 1'b0, 1'b0, 32'h0, 1'b0);
        miss_a("a_post_reset", 32'h0000_1040);

        update(32'h0000_1000, 32'h0000_7000, 1'b1);
        update(32'h0000_1040, 32'h0000_7040, 1'b1);
        update(32'h0000_1080, 32'h0000_7080, 1'b1);
        update(32'h0000_10C0, 32'h0000_70C0, 1'b1);
        hit_b("b_w0", 32'h0000_1000, 32'h0000_7000, 1'b1);
        hit_b("b_w3", 32'h0000_10C0, 32'h0000_70C0, 1'b1);
        update(32'h0000_1100, 32'h0000_7100, 1'b1);
        miss_b("b_evict_old", 32'h0000_1000);
        hit_b("b_evict_keep", 32'h0000_1040, 32'h0000_7040, 1'b1);
        hit_b("b_evict_new", 32'h0000_1100, 32'h0000_7100, 1'b1);

        flush = 1'b1;
        upd_valid = 1'b1;
        upd_pc = 32'h0000_1140;
        upd_target = 32'h0000_7140;
        upd_taken = 1'b1;
        cyc();
        flush = 1'b0;
        upd_valid = 1'b0;
        miss_b("b_fl_1040", 32'h0000_1040);
        miss_b("b_fl_1100", 32'h0000_1100);
        miss_b("b_fl_drop", 32'h0000_1140);
        update(32'h0000_1000, 32'h0000_8000, 1'b1);
        update(32'h0000_1040, 32'h0000_8040, 1'b1);
        update(32'h0000_1080, 32'h0000_8080, 1'b1);
        update(32'h0000_10C0, 32'h0000_80C0, 1'b1);
        update(32'h0000_1100, 32'h0000_8100, 1'b1);
        miss_b("b_fl_rr_old", 32'h0000_1000);
        hit_b("b_fl_rr_keep", 32'h0000_1040, 32'h0000_8040, 1'b1);
        hit_b("b_fl_rr_new", 32'h0000_1100, 32'h0000_8100, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
